// File: rtl/header_generator.sv
// -----------------------------------------------------------------------------
// header_generator
// Candidate block-header source for the MD5 mining pipeline. Captures a secret
// key from an inbound byte stream (terminated by 0x0A), then emits one header
// per accepted handshake: key followed by an ASCII decimal counter starting
// at 1. The string is right-aligned: last character in byte 0.
//
// Ports:
//   i_clk                  sole clock
//   i_reset                synchronous, active-high reset
//   i_inbound_valid/data   inbound key byte stream (no backpressure)
//   i_halt                 stop generation (match found downstream)
//   i_block_header_ready   downstream accepts the current header
//   o_block_header_valid   header available
//   o_block_header_data    candidate string, right-aligned, zero-filled above
//   o_block_header_length  string length in bytes
//   o_exhausted            whole counter range has been emitted
// -----------------------------------------------------------------------------
module header_generator #(
   parameter int KEY_MAX_CHARS      = 8,
   parameter int DIGITS             = 8,
   parameter int BLOCK_HEADER_WIDTH = 128
) (
   input  logic                                        i_clk,
   input  logic                                        i_reset,
   input  logic                                        i_inbound_valid,
   input  logic [7:0]                                  i_inbound_data,
   input  logic                                        i_halt,
   input  logic                                        i_block_header_ready,
   output logic                                        o_block_header_valid,
   output logic [BLOCK_HEADER_WIDTH-1:0]               o_block_header_data,
   output logic [$clog2(KEY_MAX_CHARS+DIGITS+1)-1:0]   o_block_header_length,
   output logic                                        o_exhausted
);

   localparam int LW  = $clog2(KEY_MAX_CHARS+DIGITS+1);
   localparam int KLW = $clog2(KEY_MAX_CHARS+1);
   localparam int NDW = $clog2(DIGITS+1);

   localparam logic [1:0] S_LOAD_KEY  = 2'd0;
   localparam logic [1:0] S_RUN       = 2'd1;
   localparam logic [1:0] S_STOPPED   = 2'd2;
   localparam logic [1:0] S_EXHAUSTED = 2'd3;

   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

   generate
      if (BLOCK_HEADER_WIDTH < 8*(KEY_MAX_CHARS+DIGITS)) begin : g_width_check
         $error("BLOCK_HEADER_WIDTH too small for KEY_MAX_CHARS+DIGITS bytes");
      end
   endgenerate

   logic [1:0]                    r_state, w_state;
   logic [8*KEY_MAX_CHARS-1:0]    r_key, w_key;
   logic [KLW-1:0]                r_key_len, w_key_len;
   logic [4*DIGITS-1:0]           r_bcd, w_bcd, w_inc_bcd;
   logic [NDW-1:0]                r_num_digits, w_num_digits, w_inc_nd;
   logic                          r_valid;
   logic                          r_exhausted;
   logic [BLOCK_HEADER_WIDTH-1:0] r_data, w_data;
   logic [LW-1:0]                 r_len;
   logic                          w_hs;

   assign w_hs = r_valid & i_block_header_ready;

   // BCD increment with ripple carry; a carry landing in a digit at or above
   // the current digit count extends the count to cover that digit.
   always_comb begin
      logic carry;
      carry     = 1'b1;
      w_inc_bcd = r_bcd;
      w_inc_nd  = r_num_digits;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (d >= 32'(r_num_digits)) w_inc_nd = NDW'(d + 1);
            if (r_bcd[4*d +: 4] == 4'h9) begin
               w_inc_bcd[4*d +: 4] = 4'h0;
            end else begin
               w_inc_bcd[4*d +: 4] = r_bcd[4*d +: 4] + 4'h1;
               carry = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_state      = r_state;
      w_key        = r_key;
      w_key_len    = r_key_len;
      w_bcd        = r_bcd;
      w_num_digits = r_num_digits;
      case (r_state)
         S_LOAD_KEY: begin
            if (i_halt) begin
               w_state = S_STOPPED;
            end else if (i_inbound_valid) begin
               if (i_inbound_data == 8'h0A) begin
                  w_state      = S_RUN;
                  w_bcd        = '0;
                  w_bcd[3:0]   = 4'h1;
                  w_num_digits = NDW'(1);
               end else if (i_inbound_data != 8'h0D &&
                            r_key_len < KLW'(KEY_MAX_CHARS)) begin
                  w_key       = r_key << 8;
                  w_key[7:0]  = i_inbound_data;
                  w_key_len   = r_key_len + KLW'(1);
               end
            end
         end
         S_RUN: begin
            if (w_hs) begin
               if (r_bcd == ALL_NINES) begin
                  w_state = S_EXHAUSTED;
               end else begin
                  w_bcd        = w_inc_bcd;
                  w_num_digits = w_inc_nd;
               end
            end
            // A handshake in the halt cycle has already been counted above.
            if (i_halt && w_state == S_RUN) w_state = S_STOPPED;
         end
         default: ;
      endcase
   end

   // Header is built from next-state values so the registered output tracks
   // the counter with no bubble after each handshake.
   always_comb begin
      w_data = '0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (d < 32'(w_num_digits)) w_data[8*d +: 8] = {4'h3, w_bcd[4*d +: 4]};
      end
      for (int unsigned k = 0; k < KEY_MAX_CHARS; k++) begin
         if (k < 32'(w_key_len))
            w_data[8*(32'(w_num_digits) + k) +: 8] = w_key[8*k +: 8];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_LOAD_KEY;
         r_key        <= '0;
         r_key_len    <= '0;
         r_bcd        <= '0;
         r_num_digits <= '0;
         r_valid      <= 1'b0;
         r_exhausted  <= 1'b0;
         r_data       <= '0;
         r_len        <= '0;
      end else begin
         r_state      <= w_state;
         r_key        <= w_key;
         r_key_len    <= w_key_len;
         r_bcd        <= w_bcd;
         r_num_digits <= w_num_digits;
         r_valid      <= (w_state == S_RUN);
         r_exhausted  <= (w_state == S_EXHAUSTED);
         r_data       <= (w_state == S_RUN) ? w_data : '0;
         r_len        <= (w_state == S_RUN) ? (LW'(w_key_len) + LW'(w_num_digits)) : '0;
      end
   end

   assign o_block_header_valid  = r_valid;
   assign o_block_header_data   = r_data;
   assign o_block_header_length = r_len;
   assign o_exhausted           = r_exhausted;

endmodule

// File: tb/tb_header_generator.sv
// -----------------------------------------------------------------------------
// tb_header_generator
// Randomized self-checking bench. Instance A (default parameters) is compared
// every cycle against a string/integer level model; instance B (DIGITS=2)
// covers counter exhaustion.
// -----------------------------------------------------------------------------
module tb_header_generator;

   localparam int KMAX   = 8;
   localparam int MAXN_A = 99999999;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   // instance A
   logic         a_reset = 1'b1, a_iv = 1'b0, a_halt = 1'b0, a_ready = 1'b0;
   logic [7:0]   a_id = 8'h00;
   logic         a_valid, a_exh;
   logic [127:0] a_data;
   logic [4:0]   a_len;

   // instance B
   logic         b_reset = 1'b1, b_iv = 1'b0, b_halt = 1'b0, b_ready = 1'b0;
   logic [7:0]   b_id = 8'h00;
   logic         b_valid, b_exh;
   logic [79:0]  b_data;
   logic [3:0]   b_len;

   header_generator #(.KEY_MAX_CHARS(KMAX), .DIGITS(8), .BLOCK_HEADER_WIDTH(128)) u_dut_a (
      .i_clk(clk), .i_reset(a_reset), .i_inbound_valid(a_iv), .i_inbound_data(a_id),
      .i_halt(a_halt), .i_block_header_ready(a_ready),
      .o_block_header_valid(a_valid), .o_block_header_data(a_data),
      .o_block_header_length(a_len), .o_exhausted(a_exh));

   header_generator #(.KEY_MAX_CHARS(8), .DIGITS(2), .BLOCK_HEADER_WIDTH(80)) u_dut_b (
      .i_clk(clk), .i_reset(b_reset), .i_inbound_valid(b_iv), .i_inbound_data(b_id),
      .i_halt(b_halt), .i_block_header_ready(b_ready),
      .o_block_header_valid(b_valid), .o_block_header_data(b_data),
      .o_block_header_length(b_len), .o_exhausted(b_exh));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 loading key, 1 running, 2 stopped, 3 exhausted
   int         m_mode = 0;
   int         m_n    = 0;
   logic [7:0] m_key[$];

   function automatic int ndig(input int n);
      int c = 1;
      while (n >= 10) begin n = n / 10; c++; end
      return c;
   endfunction

   // key string followed by decimal n, last character in byte 0
   function automatic logic [127:0] hdr(input logic [7:0] k[$], input int n);
      logic [127:0] h = '0;
      int pos = 0;
      int m = n;
      do begin
         h[8*pos +: 8] = 8'h30 + 8'(m % 10);
         m = m / 10;
         pos++;
      end while (m > 0);
      for (int i = k.size() - 1; i >= 0; i--) begin
         h[8*pos +: 8] = k[i];
         pos++;
      end
      return h;
   endfunction

   task automatic step_a();
      @(posedge clk);
      if (a_reset) begin
         m_mode = 0; m_n = 0; m_key.delete();
      end else if (m_mode == 0) begin
         if (a_halt) m_mode = 2;
         else if (a_iv) begin
            if (a_id == 8'h0A) begin m_mode = 1; m_n = 1; end
            else if (a_id != 8'h0D && m_key.size() < KMAX) m_key.push_back(a_id);
         end
      end else if (m_mode == 1) begin
         if (a_ready) begin
            if (m_n == MAXN_A) m_mode = 3;
            else m_n++;
         end
         if (a_halt && m_mode == 1) m_mode = 2;
      end
      #1;
      check("valid", a_valid, m_mode == 1);
      check("exhausted", a_exh, m_mode == 3);
      if (m_mode == 1) begin
         check("data", a_data, hdr(m_key, m_n));
         check("length", a_len, 128'(m_key.size() + ndig(m_n)));
      end else if (a_reset) begin
         check("rst_data", a_data, '0);
         check("rst_length", a_len, '0);
      end
   endtask

   task automatic send_a(input logic [7:0] b);
      a_iv = 1'b1; a_id = b;
      step_a();
      a_iv = 1'b0; a_id = 8'h00;
   endtask

   task automatic send_str_a(input string s);
      for (int i = 0; i < s.len(); i++) send_a(s[i]);
   endtask

   task automatic reset_a();
      a_reset = 1'b1; a_halt = 1'b0; a_iv = 1'b0;
      step_a();
      a_reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] bk[$];
      // reset state
      step_a();
      step_a();
      a_reset = 1'b0;

      // key load and sequence
      a_ready = 1'b1;
      send_str_a("abcdef");
      send_a(8'h0A);
      check("first_hdr", a_data, "abcdef1");
      check("first_len", a_len, 7);
      for (int i = 0; i < 9; i++) step_a();
      check("tenth_hdr", a_data, "abcdef10");
      check("tenth_len", a_len, 8);

      // backpressure with random ready and ignored inbound bytes
      for (int i = 0; i < 200; i++) begin
         a_ready = 1'($urandom_range(0, 1));
         a_iv    = 1'($urandom_range(0, 1));
         a_id    = 8'($urandom);
         step_a();
      end
      a_iv = 1'b0;

      // halt together with the handshake of counter 5
      reset_a();
      a_ready = 1'b1;
      send_str_a("ab");
      send_a(8'h0A);
      for (int i = 0; i < 4; i++) step_a();
      check("pre_halt_hdr", a_data, "ab5");
      a_halt = 1'b1;
      step_a();
      a_halt = 1'b0;
      for (int i = 0; i < 20; i++) step_a();

      // halt during a stall
      reset_a();
      a_ready = 1'b0;
      send_str_a("cd");
      send_a(8'h0A);
      for (int i = 0; i < 3; i++) step_a();
      a_halt = 1'b1;
      step_a();
      a_halt = 1'b0;
      a_ready = 1'b1;
      for (int i = 0; i < 5; i++) step_a();

      // empty key
      reset_a();
      send_a(8'h0A);
      check("empty_hdr", a_data, 8'h31);
      check("empty_len", a_len, 1);

      // over-long key with an embedded CR
      reset_a();
      a_ready = 1'b0;
      send_str_a("ABCD");
      send_a(8'h0D);
      send_str_a("EFGHIJK");
      send_a(8'h0A);
      check("long_hdr", a_data, "ABCDEFGH1");
      check("long_len", a_len, KMAX + 1);

      // reset mid-run at counter 37, then reload
      reset_a();
      a_ready = 1'b1;
      send_str_a("zz");
      send_a(8'h0A);
      for (int i = 0; i < 36; i++) step_a();
      check("pre_reset_hdr", a_data, "zz37");
      a_reset = 1'b1;
      step_a();
      check("mid_rst_valid", a_valid, 1'b0);
      check("mid_rst_data", a_data, '0);
      a_reset = 1'b0;
      send_str_a("xy");
      send_a(8'h0A);
      check("reload_hdr", a_data, "xy1");
      check("reload_len", a_len, 3);
      for (int i = 0; i < 40; i++) begin
         a_ready = 1'($urandom_range(0, 1));
         a_iv    = 1'b1;
         a_id    = 8'($urandom_range(8'h41, 8'h5A));
         step_a();
      end
      a_iv = 1'b0;

      // exhaustion on the 2-digit instance, key "k"
      bk.push_back(8'h6B);
      @(posedge clk); #1;
      check("b_reset_valid", b_valid, 1'b0);
      b_reset = 1'b0; b_ready = 1'b1;
      b_iv = 1'b1; b_id = 8'h6B;
      @(posedge clk); #1;
      b_id = 8'h0A;
      @(posedge clk); #1;
      b_iv = 1'b0; b_id = 8'h00;
      for (int n = 1; n <= 99; n++) begin
         check("b_valid", b_valid, 1'b1);
         check("b_exh_low", b_exh, 1'b0);
         check("b_data", b_data, hdr(bk, n));
         check("b_len", b_len, 128'(1 + ndig(n)));
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         check("b_done_valid", b_valid, 1'b0);
         check("b_exhausted", b_exh, 1'b1);
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/header_generator.md
# header_generator

Upstream candidate source for the MD5 mining pipeline. Captures the secret key from the inbound byte stream, then emits one candidate block header per accepted handshake: key immediately followed by an incrementing ASCII decimal counter starting at 1. Each header feeds the MD5 stage and the downstream suffix extractor, which recovers the counter value from the right-aligned digit bytes.

## Interface
- `KEY_MAX_CHARS`, default 8: maximum secret key length in bytes.
- `DIGITS`, default 8: counter width in decimal digits.
- `BLOCK_HEADER_WIDTH`, default 128: header width in bits; must be ≥ 8*(KEY_MAX_CHARS+DIGITS) (elaboration assertion).
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `inbound_valid` in 1: inbound byte strobe, no backpressure.
- `inbound_data` in 8: inbound byte.
- `halt` in 1: stop generation (match found downstream).
- `block_header_ready` in 1: downstream accepts header.
- `block_header_valid` out 1: header available.
- `block_header_data` out BLOCK_HEADER_WIDTH: candidate string, right-aligned.
- `block_header_length` out $clog2(KEY_MAX_CHARS+DIGITS+1): string length in bytes.
- `exhausted` out 1: counter range fully emitted.

## Operation
- States: LOAD_KEY (after reset), RUN, STOPPED, EXHAUSTED.
- LOAD_KEY: each `inbound_valid` byte other than 0x0A/0x0D shifts into the key register: key = (key << 8) | byte, key_len++. Bytes beyond KEY_MAX_CHARS are dropped; key_len saturates. 0x0D is ignored. 0x0A moves the FSM to RUN with BCD counter = 1, num_digits = 1.
- Bytes arriving outside LOAD_KEY are ignored.
- Header layout:
  - Last character at byte 0, first character at the highest used byte.
  - Digit d (least significant = 0) at byte d, coded 0x30+BCD.
  - Key occupies bytes num_digits .. num_digits+key_len-1.
  - All higher bytes are 0x00.
  - Length = key_len + num_digits.
- Counter: DIGITS-digit BCD incrementer with per-digit carry. num_digits increments when a carry enters a previously unused digit, e.g. 9→10 and 99→100.
- RUN: `block_header_valid` = 1. A handshake (valid & ready) advances the counter.
- Handshake on counter = all nines (10^DIGITS − 1) moves to EXHAUSTED. `exhausted` = 1 and `block_header_valid` = 0 until reset.
- `halt` = 1 in RUN moves to STOPPED. A handshake in the same cycle as `halt` still counts as transferred, and no further headers follow. STOPPED holds `block_header_valid` = 0 until reset.
- `halt` in LOAD_KEY moves to STOPPED; no header is ever emitted.
- Empty key (0x0A first): headers are pure digits.

## Timing
- Reset values: `block_header_valid` 0, `block_header_data` 0, `block_header_length` 0, `exhausted` 0; key, key_len and counter cleared; state LOAD_KEY.
- Reset asserted mid-run:
  - Outputs take reset values on the next edge.
  - The key must be reloaded.
- The 0x0A byte accepted at edge t gives `block_header_valid` = 1 with counter 1 from edge t+1.
- Outputs are registered. On a handshake at edge t, the next header (value n+1) is presented from edge t+1. Sustained ready gives one header per cycle with no bubbles, including across digit-count growth.
- While valid & !ready, data and length stay stable; valid never drops except via halt, exhaustion or reset.
- `halt` sampled at edge t gives `block_header_valid` = 0 from edge t+1.
- Final handshake at edge t gives valid = 0 and `exhausted` = 1 from edge t+1.

## Test plan
- Key load and sequence: bytes "abcdef",0x0A, ready=1.
  - First header: bytes[6:0] = "abcdef1" (byte 0 = 0x31, byte 6 = 0x61), length 7, one cycle after 0x0A.
  - Consecutive headers end in "2".."9".
  - Tenth header: "abcdef10", length 8; byte 0 = 0x30, byte 1 = 0x31, byte 7 = 0x61.
- Backpressure: with ready toggling pseudo-randomly for 200 cycles, the accepted headers carry strictly consecutive counters 1..N. Data is stable throughout every stall.
- Halt:
  - Assert `halt` together with the handshake of counter 5: counter 5 is counted, valid = 0 next cycle and stays 0 for 20 cycles despite ready.
  - Separately, `halt` during a stall: no handshake occurs.
- Exhaustion (DIGITS=2, key "k"): headers "k1".."k99"; after the "k99" handshake, `exhausted` = 1 and valid = 0.
- Edge keys:
  - Empty key (0x0A only): first header = 0x31, length 1.
  - Key of KEY_MAX_CHARS+3 chars: the first KEY_MAX_CHARS are kept; length = KEY_MAX_CHARS+1 on the first header.
  - A 0x0D before 0x0A is ignored.
- Reset mid-run at counter 37:
  - All outputs return to 0 on the next edge.
  - Reloading "xy",0x0A restarts at "xy1".
  - Bytes sent while in RUN do not alter the key.
